mwadd48_seq: RTL

MWADD48_SEQ -- requirements
Module: mwadd48_seq

---
 rtl/mwadd48_pkg.sv | 10 +
 rtl/csa_48bit.sv | 26 ++
 rtl/mwadd48_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mwadd48_pkg.sv
// Shared types and default sizing for the multi-word sequential adder.
package mwadd48_pkg;
   localparam int DEF_WIDTH     = 48;
   localparam int DEF_MAX_BEATS = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/csa_48bit.sv
// Carry-select adder core: a + b + cin, purely combinational.
// Latency 0; no flow control.
module csa_48bit #(
   parameter int WIDTH = 48
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int LO = WIDTH / 2;
   localparam int HI = WIDTH - LO;

   logic [LO:0] lo_s;
   logic [HI:0] hi0;
   logic [HI:0] hi1;

   // Upper half is computed for both possible carries, then selected.
   assign lo_s = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + {{LO{1'b0}}, cin};
   assign hi0  = {1'b0, a[WIDTH-1:LO]} + {1'b0, b[WIDTH-1:LO]};
   assign hi1  = hi0 + {{HI{1'b0}}, 1'b1};

   assign sum  = {(lo_s[LO] ? hi1[HI-1:0] : hi0[HI-1:0]), lo_s[LO-1:0]};
   assign cout = lo_s[LO] ? hi1[HI] : hi0[HI];
endmodule

// File: rtl/mwadd48_seq.sv
// Multi-word adder, LS word first, one beat per cycle; MWADD48_SUB_EN adds i_sub (A - B).
// Latency 1 cycle accept->o_valid; o_ready = !o_valid || i_ready, outputs held while stalled.
module mwadd48_seq
   import mwadd48_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int MAX_BEATS = DEF_MAX_BEATS
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_add_term1,
   input  logic [WIDTH-1:0] i_add_term2,
   input  logic             i_first,
   input  logic             i_last,
`ifdef MWADD48_SUB_EN
   input  logic             i_sub,
`endif
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_last,
   output logic             o_cout,
   output logic             o_err
);
   localparam int CW = $clog2(MAX_BEATS + 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic            carry_q;
   logic            accept;
   logic            emit;
   logic            err_set;
   logic            init_cin;
   logic            core_cin;
   logic [WIDTH-1:0] core_b;
   logic [WIDTH-1:0] core_sum;
   logic            core_cout;

   assign o_ready = !o_valid || i_ready;
   assign accept  = i_valid && o_ready;

`ifdef MWADD48_SUB_EN
   logic sub_q;
   logic sub_eff;

   // The mode is latched on the first beat and applies to the whole operation.
   assign sub_eff  = i_first ? i_sub : sub_q;
   assign core_b   = sub_eff ? ~i_add_term2 : i_add_term2;
   assign init_cin = sub_eff;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sub_q <= 1'b0;
      end else if (accept && i_first) begin
         sub_q <= i_sub;
      end
   end
`else
   assign core_b   = i_add_term2;
   assign init_cin = 1'b0;
`endif

   assign core_cin = i_first ? init_cin : carry_q;

   csa_48bit #(.WIDTH(WIDTH)) u_core (
      .a    (i_add_term1),
      .b    (core_b),
      .cin  (core_cin),
      .sum  (core_sum),
      .cout (core_cout)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      emit    = 1'b0;
      err_set = 1'b0;
      if (accept) begin
         if (i_first) begin
            // A first beat always restarts, even in the middle of an operation.
            emit    = 1'b1;
            count_d = CW'(1);
            state_d = i_last ? IDLE : RUN;
         end else if (state_q == IDLE) begin
            err_set = 1'b1;
         end else if (count_q == CW'(MAX_BEATS)) begin
            err_set = 1'b1;
            state_d = IDLE;
         end else begin
            emit    = 1'b1;
            count_d = count_q + 1'b1;
            if (i_last) begin
               state_d = IDLE;
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         count_q <= '0;
         carry_q <= 1'b0;
         o_err   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (accept) begin
            carry_q <= core_cout;
         end
         if (err_set) begin
            o_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_valid <= 1'b0;
         o_sum   <= '0;
         o_last  <= 1'b0;
         o_cout  <= 1'b0;
      end else if (emit) begin
         o_valid <= 1'b1;
         o_sum   <= core_sum;
         o_last  <= i_last;
         o_cout  <= i_last & core_cout;
      end else if (o_ready) begin
         o_valid <= 1'b0;
      end
   end
endmodule
